rps_judge: RTL and testbench

Round-resolution stage of the game datapath, directly downstream of the random opponent-choice generator. It collects the player's move and the opponent move, and scores each round as a tie, player win or opponent win. It keeps both running scores and declares a match winner when either side reaches a target count. Its result and score outputs drive the display and LED logic.

---
 rtl/rps_judge.sv | 223 ++++++++++++++++++++++
 tb/tb_rps_judge.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rps_judge.sv
// rps_judge: scores rock/paper/scissors rounds between the player and the
// opponent-choice generator, keeps both running scores and declares the
// match winner once either side reaches WIN_TARGET round wins.
//
// Optional feature macro: RPS_TIMEOUT_EN -- when defined, the player forfeits
// the round after TIMEOUT_CYCLES cycles in WP without an accepted move.
//
// Ports:
//   Clk, Reset          clock; asynchronous active-high reset
//   Start               single-cycle pulse, begins (or restarts) a match
//   P_Valid, P_Choice   player move (00 rock, 01 paper, 10 scissors, 11 invalid)
//   C_Valid, C_Choice   opponent move, same encoding
//   P_Ready, C_Req      waiting for player / opponent move
//   Round_Done          one-cycle pulse, Round_Result and scores are valid
//   Round_Result        00 tie, 01 player won, 10 opponent won, 11 none
//   P_Score, C_Score    round wins per side
//   Match_Over          high while in DONE
//   Match_Winner        0 player, 1 opponent; valid while Match_Over
//   q_INI..q_DONE       one-hot state outputs
module rps_judge #(
  parameter int unsigned WIN_TARGET     = 3,
  parameter int unsigned SCORE_W        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               P_Valid,
  input  logic [1:0]         P_Choice,
  input  logic               C_Valid,
  input  logic [1:0]         C_Choice,
  output logic               P_Ready,
  output logic               C_Req,
  output logic               Round_Done,
  output logic [1:0]         Round_Result,
  output logic [SCORE_W-1:0] P_Score,
  output logic [SCORE_W-1:0] C_Score,
  output logic               Match_Over,
  output logic               Match_Winner,
  output logic               q_INI,
  output logic               q_WP,
  output logic               q_WC,
  output logic               q_EVAL,
  output logic               q_RES,
  output logic               q_DONE
);

  localparam logic [1:0] MOVE_INVALID = 2'b11;
  localparam logic [1:0] RES_TIE      = 2'b00;
  localparam logic [1:0] RES_PLAYER   = 2'b01;
  localparam logic [1:0] RES_OPP      = 2'b10;
  localparam logic [1:0] RES_NONE     = 2'b11;

  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

  typedef enum logic [5:0] {
    S_INI  = 6'b000001,
    S_WP   = 6'b000010,
    S_WC   = 6'b000100,
    S_EVAL = 6'b001000,
    S_RES  = 6'b010000,
    S_DONE = 6'b100000
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         p_move_q, p_move_d;
  logic [1:0]         c_move_q, c_move_d;
  logic [1:0]         result_q, result_d;
  logic [SCORE_W-1:0] p_score_q, p_score_d;
  logic [SCORE_W-1:0] c_score_q, c_score_d;
  logic               winner_q, winner_d;
  logic               p_ready_q, p_ready_d;
  logic               c_req_q, c_req_d;
  logic               done_q, done_d;
  logic               over_q, over_d;

  // d = (P - C) mod 3, evaluated as (P + 3 - C) folded once; the 2-bit
  // remainder is directly the Round_Result encoding.
  logic [2:0] diff_raw;
  logic [1:0] diff_mod;

  always_comb begin
    diff_raw = 3'({1'b0, p_move_q}) + 3'd3 - 3'({1'b0, c_move_q});
    diff_mod = (diff_raw >= 3'd3) ? 2'(diff_raw - 3'd3) : 2'(diff_raw);
  end

`ifdef RPS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state and next-output computation.
  always_comb begin
    state_d   = state_q;
    p_move_d  = p_move_q;
    c_move_d  = c_move_q;
    result_d  = result_q;
    p_score_d = p_score_q;
    c_score_d = c_score_q;
    winner_d  = winner_q;
`ifdef RPS_TIMEOUT_EN
    cnt_d     = '0;
`endif

    unique case (state_q)
      S_INI: begin
        if (Start) state_d = S_WP;
      end
      S_WP: begin
        if (P_Valid && (P_Choice != MOVE_INVALID)) begin
          p_move_d = P_Choice;
          state_d  = S_WC;
        end
`ifdef RPS_TIMEOUT_EN
        // Expiry loses to an accepted move in the same cycle.
        else if (cnt_q == CNT_LAST) begin
          result_d  = RES_OPP;
          c_score_d = c_score_q + SCORE_W'(1);
          state_d   = S_RES;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_WC: begin
        if (C_Valid && (C_Choice != MOVE_INVALID)) begin
          c_move_d = C_Choice;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        result_d = diff_mod;
        if (diff_mod == RES_PLAYER) p_score_d = p_score_q + SCORE_W'(1);
        if (diff_mod == RES_OPP)    c_score_d = c_score_q + SCORE_W'(1);
        state_d = S_RES;
      end
      S_RES: begin
        if ((p_score_q == TARGET) || (c_score_q == TARGET)) begin
          winner_d = (c_score_q == TARGET);
          state_d  = S_DONE;
        end else begin
          state_d = S_WP;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_INI;
    endcase

    // Start overrides every other transition and begins a fresh match.
    if (Start) begin
      state_d   = S_WP;
      p_score_d = '0;
      c_score_d = '0;
      result_d  = RES_NONE;
      winner_d  = 1'b0;
`ifdef RPS_TIMEOUT_EN
      cnt_d     = '0;
`endif
    end

    // Status outputs are registered copies of the upcoming state.
    p_ready_d = (state_d == S_WP);
    c_req_d   = (state_d == S_WC);
    done_d    = (state_d == S_RES);
    over_d    = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_INI;
      p_move_q  <= 2'b00;
      c_move_q  <= 2'b00;
      result_q  <= RES_NONE;
      p_score_q <= '0;
      c_score_q <= '0;
      winner_q  <= 1'b0;
      p_ready_q <= 1'b0;
      c_req_q   <= 1'b0;
      done_q    <= 1'b0;
      over_q    <= 1'b0;
`ifdef RPS_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      p_move_q  <= p_move_d;
      c_move_q  <= c_move_d;
      result_q  <= result_d;
      p_score_q <= p_score_d;
      c_score_q <= c_score_d;
      winner_q  <= winner_d;
      p_ready_q <= p_ready_d;
      c_req_q   <= c_req_d;
      done_q    <= done_d;
      over_q    <= over_d;
`ifdef RPS_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign P_Ready      = p_ready_q;
  assign C_Req        = c_req_q;
  assign Round_Done   = done_q;
  assign Round_Result = result_q;
  assign P_Score      = p_score_q;
  assign C_Score      = c_score_q;
  assign Match_Over   = over_q;
  assign Match_Winner = winner_q;

  // One-hot state bits straight from the state register.
  assign q_INI  = state_q[0];
  assign q_WP   = state_q[1];
  assign q_WC   = state_q[2];
  assign q_EVAL = state_q[3];
  assign q_RES  = state_q[4];
  assign q_DONE = state_q[5];

endmodule

// File: tb/tb_rps_judge.sv
// Directed bench for rps_judge: reset, single round, all move pairs, full
// match, invalid moves, abort, async reset, back-to-back rounds and
// (when RPS_TIMEOUT_EN is defined) the player-move timeout.
module tb_rps_judge;

  localparam int unsigned SW = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic          P_Valid;
  logic [1:0]    P_Choice;
  logic          C_Valid;
  logic [1:0]    C_Choice;
  logic          P_Ready, C_Req, Round_Done, Match_Over, Match_Winner;
  logic [1:0]    Round_Result;
  logic [SW-1:0] P_Score, C_Score;
  logic          q_INI, q_WP, q_WC, q_EVAL, q_RES, q_DONE;

  int n_checks = 0;
  int n_fail   = 0;

  rps_judge #(.WIN_TARGET(3), .SCORE_W(SW), .TIMEOUT_CYCLES(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .P_Valid(P_Valid), .P_Choice(P_Choice),
    .C_Valid(C_Valid), .C_Choice(C_Choice),
    .P_Ready(P_Ready), .C_Req(C_Req), .Round_Done(Round_Done),
    .Round_Result(Round_Result), .P_Score(P_Score), .C_Score(C_Score),
    .Match_Over(Match_Over), .Match_Winner(Match_Winner),
    .q_INI(q_INI), .q_WP(q_WP), .q_WC(q_WC), .q_EVAL(q_EVAL),
    .q_RES(q_RES), .q_DONE(q_DONE)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; P_Valid = 1'b0; P_Choice = 2'b00;
    C_Valid = 1'b0; C_Choice = 2'b00;
    @(negedge Clk);
    Reset = 1'b0;
    tick();
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Plays one round from WP; samples outputs during the RES cycle.
  task automatic play_round(input logic [1:0] p, input logic [1:0] c,
                            output logic done, output logic [1:0] res,
                            output logic [SW-1:0] ps, output logic [SW-1:0] cs);
    P_Valid = 1'b1; P_Choice = p;
    tick();
    P_Valid = 1'b0; C_Valid = 1'b1; C_Choice = c;
    tick();
    C_Valid = 1'b0;
    tick();
    done = Round_Done; res = Round_Result; ps = P_Score; cs = C_Score;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; P_Valid = 1'b0; P_Choice = 2'b00;
    C_Valid = 1'b0; C_Choice = 2'b00;
    tick();
    n_checks++;
    if ({q_INI, q_WP, q_WC, q_EVAL, q_RES, q_DONE} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 100000",
               {q_INI, q_WP, q_WC, q_EVAL, q_RES, q_DONE});
    end
    n_checks++;
    if ({P_Score, C_Score, Round_Result} !== {4'd0, 4'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL reset_scores: got ps=%0d cs=%0d res=%b expected 0 0 11",
               P_Score, C_Score, Round_Result);
    end
    n_checks++;
    if ({Round_Done, P_Ready, C_Req, Match_Over, Match_Winner} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {Round_Done, P_Ready, C_Req, Match_Over, Match_Winner});
    end
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    n_checks++;
    if (q_INI !== 1'b1) begin
      n_fail++;
      $display("FAIL ini_hold: q_INI got %b expected 1", q_INI);
    end
  endtask

  task automatic test_first_round();
    do_reset();
    start_pulse();
    n_checks++;
    if ({q_WP, P_Ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_to_wp: got q_WP=%b P_Ready=%b expected 1 1", q_WP, P_Ready);
    end
    P_Valid = 1'b1; P_Choice = 2'b01;
    tick();
    P_Valid = 1'b0;
    n_checks++;
    if ({q_WC, C_Req, P_Ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL wc_entry: got %b expected 110", {q_WC, C_Req, P_Ready});
    end
    C_Valid = 1'b1; C_Choice = 2'b00;
    tick();
    C_Valid = 1'b0;
    n_checks++;
    if ({q_EVAL, Round_Done, C_Req} !== 3'b100) begin
      n_fail++;
      $display("FAIL eval_cycle: got %b expected 100", {q_EVAL, Round_Done, C_Req});
    end
    tick();
    n_checks++;
    if ({Round_Done, q_RES, Round_Result, P_Score, C_Score} !== {1'b1, 1'b1, 2'b01, 4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL first_round: got done=%b res=%b ps=%0d cs=%0d expected 1 01 1 0",
               Round_Done, Round_Result, P_Score, C_Score);
    end
    tick();
    n_checks++;
    if ({Round_Done, q_WP, Round_Result} !== {1'b0, 1'b1, 2'b01}) begin
      n_fail++;
      $display("FAIL after_res: got done=%b q_WP=%b res=%b expected 0 1 01",
               Round_Done, q_WP, Round_Result);
    end
  endtask

  task automatic test_all_pairs();
    logic [1:0] exp_tab [9] = '{2'b00, 2'b10, 2'b01,
                                2'b01, 2'b00, 2'b10,
                                2'b10, 2'b01, 2'b00};
    logic done; logic [1:0] res; logic [SW-1:0] ps, cs;
    for (int i = 0; i < 9; i++) begin
      logic [SW-1:0] eps, ecs;
      eps = (exp_tab[i] == 2'b01) ? 4'd1 : 4'd0;
      ecs = (exp_tab[i] == 2'b10) ? 4'd1 : 4'd0;
      do_reset();
      start_pulse();
      play_round(2'(i / 3), 2'(i % 3), done, res, ps, cs);
      n_checks++;
      if ({done, res, ps, cs} !== {1'b1, exp_tab[i], eps, ecs}) begin
        n_fail++;
        $display("FAIL pair_p%0d_c%0d: got done=%b res=%b ps=%0d cs=%0d expected 1 %b %0d %0d",
                 i / 3, i % 3, done, res, ps, cs, exp_tab[i], eps, ecs);
      end
    end
  endtask

  task automatic test_match();
    logic done; logic [1:0] res; logic [SW-1:0] ps, cs;
    do_reset();
    start_pulse();
    play_round(2'b01, 2'b00, done, res, ps, cs);
    play_round(2'b00, 2'b01, done, res, ps, cs);
    play_round(2'b10, 2'b01, done, res, ps, cs);
    n_checks++;
    if ({q_WP, Match_Over, ps, cs} !== {1'b1, 1'b0, 4'd2, 4'd1}) begin
      n_fail++;
      $display("FAIL match_mid: got q_WP=%b over=%b ps=%0d cs=%0d expected 1 0 2 1",
               q_WP, Match_Over, ps, cs);
    end
    play_round(2'b00, 2'b10, done, res, ps, cs);
    n_checks++;
    if ({done, res, ps, cs} !== {1'b1, 2'b01, 4'd3, 4'd1}) begin
      n_fail++;
      $display("FAIL match_last_round: got done=%b res=%b ps=%0d cs=%0d expected 1 01 3 1",
               done, res, ps, cs);
    end
    n_checks++;
    if ({Match_Over, Match_Winner, q_DONE, Round_Done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL match_over: got %b expected 1010",
               {Match_Over, Match_Winner, q_DONE, Round_Done});
    end
    tick(); tick();
    n_checks++;
    if ({q_DONE, P_Score, C_Score, Round_Result} !== {1'b1, 4'd3, 4'd1, 2'b01}) begin
      n_fail++;
      $display("FAIL done_hold: got q_DONE=%b ps=%0d cs=%0d res=%b expected 1 3 1 01",
               q_DONE, P_Score, C_Score, Round_Result);
    end
    start_pulse();
    n_checks++;
    if ({q_WP, Match_Over, P_Score, C_Score, Round_Result} !== {1'b1, 1'b0, 4'd0, 4'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL restart: got q_WP=%b over=%b ps=%0d cs=%0d res=%b expected 1 0 0 0 11",
               q_WP, Match_Over, P_Score, C_Score, Round_Result);
    end
  endtask

  task automatic test_opponent_win();
    logic done; logic [1:0] res; logic [SW-1:0] ps, cs;
    do_reset();
    start_pulse();
    for (int i = 0; i < 3; i++) play_round(2'b10, 2'b00, done, res, ps, cs);
    n_checks++;
    if ({Match_Over, Match_Winner, C_Score, P_Score} !== {1'b1, 1'b1, 4'd3, 4'd0}) begin
      n_fail++;
      $display("FAIL opp_match: got over=%b winner=%b cs=%0d ps=%0d expected 1 1 3 0",
               Match_Over, Match_Winner, C_Score, P_Score);
    end
  endtask

  task automatic test_invalid_moves();
    do_reset();
    start_pulse();
    P_Valid = 1'b1; P_Choice = 2'b11;
    tick();
    n_checks++;
    if ({q_WP, P_Ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL p_invalid: got q_WP=%b P_Ready=%b expected 1 1", q_WP, P_Ready);
    end
    P_Choice = 2'b10;
    tick();
    // Player keeps offering a move while in WC; it must be ignored.
    P_Choice = 2'b00;
    C_Valid = 1'b1; C_Choice = 2'b11;
    tick();
    tick();
    n_checks++;
    if ({q_WC, C_Req} !== 2'b11) begin
      n_fail++;
      $display("FAIL c_invalid: got q_WC=%b C_Req=%b expected 1 1", q_WC, C_Req);
    end
    C_Choice = 2'b10;
    tick();
    P_Valid = 1'b0; C_Valid = 1'b0;
    n_checks++;
    if ({q_EVAL, C_Req} !== 2'b10) begin
      n_fail++;
      $display("FAIL c_accept: got q_EVAL=%b C_Req=%b expected 1 0", q_EVAL, C_Req);
    end
    tick();
    n_checks++;
    if ({Round_Done, Round_Result, P_Score, C_Score} !== {1'b1, 2'b00, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL invalid_round: got done=%b res=%b ps=%0d cs=%0d expected 1 00 0 0",
               Round_Done, Round_Result, P_Score, C_Score);
    end
  endtask

  task automatic test_abort();
    logic done; logic [1:0] res; logic [SW-1:0] ps, cs;
    int dones;
    do_reset();
    start_pulse();
    play_round(2'b01, 2'b00, done, res, ps, cs);
    play_round(2'b01, 2'b00, done, res, ps, cs);
    play_round(2'b00, 2'b01, done, res, ps, cs);
    P_Valid = 1'b1; P_Choice = 2'b01;
    tick();
    P_Valid = 1'b0;
    n_checks++;
    if ({q_WC, P_Score, C_Score} !== {1'b1, 4'd2, 4'd1}) begin
      n_fail++;
      $display("FAIL abort_setup: got q_WC=%b ps=%0d cs=%0d expected 1 2 1", q_WC, P_Score, C_Score);
    end
    C_Valid = 1'b1; C_Choice = 2'b00;
    start_pulse();
    C_Valid = 1'b0;
    n_checks++;
    if ({q_WP, P_Score, C_Score, Round_Result, Round_Done} !== {1'b1, 4'd0, 4'd0, 2'b11, 1'b0}) begin
      n_fail++;
      $display("FAIL abort: got q_WP=%b ps=%0d cs=%0d res=%b done=%b expected 1 0 0 11 0",
               q_WP, P_Score, C_Score, Round_Result, Round_Done);
    end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Round_Done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d Round_Done pulses expected 0", dones);
    end
  endtask

  task automatic test_async_reset();
    logic done; logic [1:0] res; logic [SW-1:0] ps, cs;
    do_reset();
    start_pulse();
    play_round(2'b01, 2'b00, done, res, ps, cs);
    P_Valid = 1'b1; P_Choice = 2'b10;
    tick();
    P_Valid = 1'b0; C_Valid = 1'b1; C_Choice = 2'b01;
    tick();
    C_Valid = 1'b0;
    n_checks++;
    if ({q_EVAL, P_Score} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL areset_setup: got q_EVAL=%b ps=%0d expected 1 1", q_EVAL, P_Score);
    end
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if ({q_INI, q_EVAL, P_Score, C_Score, Round_Result, P_Ready, C_Req, Round_Done, Match_Over}
        !== {1'b1, 1'b0, 4'd0, 4'd0, 2'b11, 4'b0000}) begin
      n_fail++;
      $display("FAIL areset: got ini=%b eval=%b ps=%0d cs=%0d res=%b flags=%b expected 1 0 0 0 11 0000",
               q_INI, q_EVAL, P_Score, C_Score, Round_Result,
               {P_Ready, C_Req, Round_Done, Match_Over});
    end
    @(negedge Clk);
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int dones;
    do_reset();
    start_pulse();
    P_Valid = 1'b1; P_Choice = 2'b00;
    C_Valid = 1'b1; C_Choice = 2'b00;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Round_Done === 1'b1) dones++;
    end
    P_Valid = 1'b0; C_Valid = 1'b0;
    n_checks++;
    if (dones !== 3) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d rounds in 12 cycles expected 3", dones);
    end
    n_checks++;
    if ({P_Score, C_Score, Round_Result} !== {4'd0, 4'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL b2b_ties: got ps=%0d cs=%0d res=%b expected 0 0 00",
               P_Score, C_Score, Round_Result);
    end
  endtask

`ifdef RPS_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    start_pulse();
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (q_WP !== 1'b1) begin
      n_fail++;
      $display("FAIL to_wait: q_WP got %b expected 1 in 8th WP cycle", q_WP);
    end
    tick();
    n_checks++;
    if ({q_RES, Round_Done, Round_Result, C_Score, P_Score} !== {1'b1, 1'b1, 2'b10, 4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL to_forfeit: got res_st=%b done=%b res=%b cs=%0d ps=%0d expected 1 1 10 1 0",
               q_RES, Round_Done, Round_Result, C_Score, P_Score);
    end
    tick();
    for (int i = 0; i < 7; i++) tick();
    P_Valid = 1'b1; P_Choice = 2'b01;
    tick();
    P_Valid = 1'b0;
    n_checks++;
    if ({q_WC, C_Score} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL to_late_accept: got q_WC=%b cs=%0d expected 1 1", q_WC, C_Score);
    end
    C_Valid = 1'b1; C_Choice = 2'b00;
    tick();
    C_Valid = 1'b0;
    tick();
    n_checks++;
    if ({Round_Done, Round_Result, P_Score, C_Score} !== {1'b1, 2'b01, 4'd1, 4'd1}) begin
      n_fail++;
      $display("FAIL to_round: got done=%b res=%b ps=%0d cs=%0d expected 1 01 1 1",
               Round_Done, Round_Result, P_Score, C_Score);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_round();
    test_all_pairs();
    test_match();
    test_opponent_win();
    test_invalid_moves();
    test_abort();
    test_async_reset();
    test_back_to_back();
`ifdef RPS_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
